// File: rtl/multicycle_sequencer_pkg.sv
// Shared miniRISC control constants: opcode/func codes, instruction classes
// and sequencer state encodings.
package miniRISC_pkg;

    localparam int OPC_W  = 6;
    localparam int FUNC_W = 5;

    localparam logic [OPC_W-1:0] OP_ALU0   = 6'd0;
    localparam logic [OPC_W-1:0] OP_ALU1   = 6'd1;
    localparam logic [OPC_W-1:0] OP_ALU2   = 6'd2;
    localparam logic [OPC_W-1:0] OP_ALUI0  = 6'd3;
    localparam logic [OPC_W-1:0] OP_ALUI1  = 6'd4;
    localparam logic [OPC_W-1:0] OP_LW     = 6'd5;
    localparam logic [OPC_W-1:0] OP_SW     = 6'd6;
    localparam logic [OPC_W-1:0] OP_BR_LO  = 6'd7;
    localparam logic [OPC_W-1:0] OP_BR_HI  = 6'd11;
    localparam logic [OPC_W-1:0] OP_BL     = 6'd12;
    localparam logic [OPC_W-1:0] OP_BR_X0  = 6'd13;
    localparam logic [OPC_W-1:0] OP_BR_X1  = 6'd14;

    // Highest legal func code for the func-qualified ALU opcodes.
    localparam logic [FUNC_W-1:0] FUNC_MAX_ALU01 = 5'd1;
    localparam logic [FUNC_W-1:0] FUNC_MAX_ALU2  = 5'd5;

    typedef enum logic [2:0] {
        ALU = 3'd0,
        LW  = 3'd1,
        SW  = 3'd2,
        BR  = 3'd3,
        BL  = 3'd4,
        ILL = 3'd5
    } instr_class_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction and data memory request/ack handshakes of the sequencer.
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;
    logic dmem_we;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/multicycle_sequencer_instr_class_decode.sv
// Maps the instruction register opcode/func fields onto an instruction class.
module instr_class_decode
    import miniRISC_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] func,
    output instr_class_t      cls
);

    always_comb begin
        cls = ILL;
        case (opcode)
            OP_ALU0, OP_ALU1:   if (func <= FUNC_MAX_ALU01) cls = ALU;
            OP_ALU2:            if (func <= FUNC_MAX_ALU2) cls = ALU;
            OP_ALUI0, OP_ALUI1: cls = ALU;
            OP_LW:              cls = LW;
            OP_SW:              cls = SW;
            OP_BL:              cls = BL;
            OP_BR_X0, OP_BR_X1: cls = BR;
            default:            if (opcode >= OP_BR_LO && opcode <= OP_BR_HI) cls = BR;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Five-phase instruction sequencer: drives phase strobes and memory handshakes,
// and keeps retired-instruction and memory-stall debug counters.
module multicycle_sequencer
    import miniRISC_pkg::*;
#(
    parameter int RET_W   = 32,
    parameter int STALL_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNC_W-1:0]   func,
    multicycle_sequencer_if.master mem,
    output logic                irWrite,
    output logic                aluEn,
    output logic                regWrite,
    output logic                pcWrite,
    output logic                illegal,
    output logic [2:0]          state,
    output logic [RET_W-1:0]    retired,
    output logic [STALL_W-1:0]  stall_cycles
);

    state_t       cur_state, nxt_state;
    instr_class_t cls, cls_q;
    logic         fetch_busy;
    logic         imem_req, dmem_req, dmem_we;
    logic         stall_evt;

    instr_class_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .cls    (cls)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= FETCH;
            cls_q      <= ILL;
            fetch_busy <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            // Keeps an unacked fetch alive even if run drops meanwhile.
            fetch_busy <= imem_req & ~mem.imem_ack;
            if (cur_state == DECODE) cls_q <= cls;
        end
    end

    // NOTE: every output and next_state gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        nxt_state = cur_state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        irWrite   = 1'b0;
        aluEn     = 1'b0;
        regWrite  = 1'b0;
        pcWrite   = 1'b0;
        illegal   = 1'b0;
        case (cur_state)
            FETCH: begin
                if (run || fetch_busy) begin
                    imem_req = 1'b1;
                    if (mem.imem_ack) begin
                        irWrite   = 1'b1;
                        nxt_state = DECODE;
                    end
                end
            end
            DECODE: nxt_state = (cls == ILL) ? TRAP : EXEC;
            EXEC: begin
                aluEn = 1'b1;
                case (cls_q)
                    ALU, BL: nxt_state = WB;
                    LW, SW:  nxt_state = MEM;
                    BR: begin
                        pcWrite   = 1'b1;
                        nxt_state = FETCH;
                    end
                    default: nxt_state = TRAP;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == SW);
                if (mem.dmem_ack) begin
                    pcWrite   = (cls_q == SW);
                    nxt_state = (cls_q == LW) ? WB : FETCH;
                end
            end
            WB: begin
                regWrite  = 1'b1;
                pcWrite   = 1'b1;
                nxt_state = FETCH;
            end
            TRAP:    illegal = 1'b1;
            default: nxt_state = FETCH;
        endcase
        // While reset is held, requests and strobes are forced low even if run=1.
        if (!rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            irWrite  = 1'b0;
            aluEn    = 1'b0;
            regWrite = 1'b0;
            pcWrite  = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign state        = cur_state;
    assign stall_evt    = (imem_req & ~mem.imem_ack) | (dmem_req & ~mem.dmem_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            if (pcWrite) retired <= retired + RET_W'(1);
            if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + STALL_W'(1);
        end
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the KGP miniRISC core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the per-phase enables and memory request handshakes. Static datapath selects (regDst, ALUsrc, ALUop, memToReg, branch selects) remain with the combinational control decode. This block only decides *when* those selects take effect. It also keeps retired-instruction and memory-stall counters for debug.

## Interface
Parameters:
- RET_W, default 32: retired-instruction counter width.
- STALL_W, default 16: stall counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  permits starting a new instruction; sampled only in FETCH before a request is issued.
- opcode  in  6  instruction-register opcode field, valid from DECODE onward.
- func  in  5  instruction-register func field.
- imem_ack  in  1  instruction memory ack; valid only while imem_req=1.
- dmem_ack  in  1  data memory ack; valid only while dmem_req=1.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe (sw); qualified by dmem_req.
- irWrite  out  1  load instruction register.
- aluEn  out  1  latch ALU result and flags.
- regWrite  out  1  register-file write strobe.
- pcWrite  out  1  update PC (sequential or branch target, as chosen by the datapath).
- illegal  out  1  sticky illegal-instruction flag.
- state  out  3  current state encoding, for debug.
- retired  out  RET_W  count of completed instructions.
- stall_cycles  out  STALL_W  count of memory wait cycles.

## Operation
States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Instruction classes, from opcode/func:
- ALU: opcode 0 with func 0–1; opcode 1 with func 0–1; opcode 2 with func 0–5; opcode 3–4.
- LW: opcode 5.
- SW: opcode 6.
- BR: opcode 7–11, 13, 14.
- BL: opcode 12.
- ILL: everything else.

State behaviour:
- FETCH:
  - If run=0: idle, no request.
  - Else: imem_req=1, held until imem_ack.
  - On the ack cycle: irWrite=1, go to DECODE.
- DECODE: one cycle. Class ILL goes to TRAP; all other classes go to EXEC.
- EXEC: aluEn=1 for one cycle. Next state by class:
  - ALU, BL → WB.
  - LW, SW → MEM.
  - BR → FETCH, with pcWrite=1 in this cycle.
- MEM:
  - dmem_req=1, and dmem_we=1 for SW; both held until dmem_ack.
  - On ack: LW → WB; SW → FETCH with pcWrite=1 in the ack cycle.
- WB: regWrite=1 and pcWrite=1 for one cycle, then → FETCH.
- TRAP: illegal=1 and all strobes 0. Only reset exits TRAP.

Handshake rules:
- An ack in the same cycle as the req is legal.
- An ack while the corresponding req=0 is ignored.
- A req, once raised, never drops before its ack.

Counters:
- retired increments on every cycle with pcWrite=1. It wraps modulo 2^RET_W.
- stall_cycles increments on each cycle with (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack). It saturates at all-ones.

Outputs are decoded from state, plus ack gating for irWrite and pcWrite in MEM. No output depends combinationally on opcode except pcWrite in EXEC.

## Timing
Reset (async, rst=0):
- state=FETCH.
- All strobes and reqs are 0.
- illegal=0, retired=0, stall_cycles=0.
- Reset asserted mid-request drops the req immediately. A pending ack is ignored.

Instruction latency with zero-wait memory (ack in the req cycle), counted from FETCH to the pcWrite cycle inclusive:
- ALU: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BR: 3 cycles.
- BL: 4 cycles.

Each wait cycle adds 1 cycle of latency and 1 count to stall_cycles.

Other timing rules:
- run falling while imem_req=1 has no effect; the fetch completes.
- opcode/func must be stable from DECODE until return to FETCH.

## Structure
Package miniRISC_pkg holds:
- Opcode and func constants, shared with the control decode.
- The instruction-class enum {ALU, LW, SW, BR, BL, ILL}.
- The state encodings.

The classification logic is a natural combinational sub-module, instr_class_decode (inputs opcode, func; output class). The FSM, output decode and counters live in multicycle_sequencer.

## Test plan
- Reset, then run=1, opcode=0/func=0 (add), zero-wait imem → irWrite at cycle 0, aluEn at cycle 2, regWrite and pcWrite at cycle 3, retired=1.
- lw (opcode 5), dmem_ack delayed 3 cycles → dmem_req high for 4 cycles, dmem_we=0, regWrite in the following cycle, stall_cycles=3, total 8 cycles.
- sw (opcode 6), zero wait → dmem_we=1 with dmem_req for 1 cycle, pcWrite in the same cycle, regWrite never asserted.
- bz (opcode 8) → pcWrite in EXEC at cycle 2, no regWrite. bl (opcode 12) → regWrite and pcWrite in WB at cycle 3.
- Illegal instruction: opcode 0/func 7, and separately opcode 15 → TRAP, illegal=1, no further imem_req despite run=1. Then rst=0 clears state to FETCH and illegal to 0.
- Edge cases:
  - run=0 in FETCH → no imem_req.
  - rst asserted during MEM with dmem_req=1 → req drops asynchronously.
  - A spurious dmem_ack in FETCH is ignored.
  - stall_cycles saturates at 0xFFFF.
